// File: rtl/ddr_queue_rd_scheduler.sv
// ddr_queue_rd_scheduler
//
// Read-side scheduler for the per-port DDR local queues. Drain requests
// (queue id plus byte budget) are held in a request table and granted
// round-robin, one queue at a time. For the granted queue the block hands
// over the budget, captures each read command the queue emits, and forwards
// it to the shared DDR read-command port. It then relays read completions
// back until the queue reports that its drain is finished.
//
// Ports
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_sched_*/o_sched_ready    drain request handshake (qid, byte budget)
//   o_sched_done/o_done_*      end-of-drain pulse with qid and issued bytes
//   o_err                      pulses with o_sched_done when a drain timed out
//   o_q_rd_byte*/i_q_rd_byte_ready   budget handoff to queue slice i
//   i_q_finish                 queue reports its drain finished
//   i_q_rd_*/o_q_rd_ready      read command from queue i
//   o_q_rd_cpl                 read completion relayed to queue i
//   o_ddr_rd_*/i_ddr_rd_ready  shared DDR read-command port
//   i_ddr_rd_cpl               outstanding DDR read finished
//   o_busy                     high whenever a drain is in progress
module ddr_queue_rd_scheduler #(
  parameter int P_QUEUE_NUM        = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_TIMEOUT          = 1024,
  localparam int QW = $clog2(P_QUEUE_NUM),
  localparam int AW = C_M_AXI_ADDR_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sched_valid,
  output logic                     o_sched_ready,
  input  logic [QW-1:0]            i_sched_qid,
  input  logic [AW-1:0]            i_sched_byte,
  output logic                     o_sched_done,
  output logic [QW-1:0]            o_done_qid,
  output logic [AW-1:0]            o_done_bytes,
  output logic                     o_err,
  output logic [P_QUEUE_NUM*AW-1:0] o_q_rd_byte,
  output logic [P_QUEUE_NUM-1:0]   o_q_rd_byte_valid,
  input  logic [P_QUEUE_NUM-1:0]   i_q_rd_byte_ready,
  input  logic [P_QUEUE_NUM-1:0]   i_q_finish,
  input  logic [P_QUEUE_NUM*AW-1:0] i_q_rd_addr,
  input  logic [P_QUEUE_NUM*16-1:0] i_q_rd_len,
  input  logic [P_QUEUE_NUM*8-1:0] i_q_rd_strb,
  input  logic [P_QUEUE_NUM-1:0]   i_q_rd_valid,
  output logic [P_QUEUE_NUM-1:0]   o_q_rd_ready,
  output logic [P_QUEUE_NUM-1:0]   o_q_rd_cpl,
  output logic [AW-1:0]            o_ddr_rd_addr,
  output logic [15:0]              o_ddr_rd_len,
  output logic [7:0]               o_ddr_rd_strb,
  output logic [QW-1:0]            o_ddr_rd_qid,
  output logic                     o_ddr_rd_valid,
  input  logic                     i_ddr_rd_ready,
  input  logic                     i_ddr_rd_cpl,
  output logic                     o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BYTE,
    S_CMD,
    S_ISSUE,
    S_WAIT_CPL,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] TIMEOUT_LAST = AW'(P_TIMEOUT - 1);

  state_e                 state_q;
  logic [P_QUEUE_NUM-1:0] pending_q;
  logic [AW-1:0]          budget_q [P_QUEUE_NUM];
  logic [QW-1:0]          rr_q;
  logic [QW-1:0]          act_q;
  logic [AW-1:0]          timer_q;
  logic [AW-1:0]          byte_cnt_q;

  logic                   grant_found_d;
  logic [QW-1:0]          grant_qid_d;
  logic [QW-1:0]          cand;
  logic                   accept;

  // A queue can take a new request only while it has nothing pending.
  assign o_sched_ready = ~pending_q[i_sched_qid];
  assign accept        = i_sched_valid & o_sched_ready & (i_sched_byte != '0);

  // First pending queue at or after the round-robin pointer. Scanning from
  // the far end lets the nearest candidate overwrite the others.
  always_comb begin
    grant_found_d = 1'b0;
    grant_qid_d   = '0;
    cand          = '0;
    for (int k = P_QUEUE_NUM - 1; k >= 0; k--) begin
      cand = rr_q + QW'(k);
      if (pending_q[cand]) begin
        grant_found_d = 1'b1;
        grant_qid_d   = cand;
      end
    end
  end

  // Ready and completion relay are decoded from the registered state so the
  // active queue sees a completion in the same cycle the DDR reports it.
  always_comb begin
    o_q_rd_ready = '0;
    o_q_rd_cpl   = '0;
    if (state_q == S_CMD || state_q == S_WAIT_CPL) begin
      o_q_rd_ready[act_q] = 1'b1;
    end
    if (state_q == S_WAIT_CPL) begin
      o_q_rd_cpl[act_q] = i_ddr_rd_cpl;
    end
  end

  // Request table, drain FSM and all registered outputs. The timeout counter
  // free-runs and is cleared on every state entry, so it measures the time
  // spent in the current state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q           <= S_IDLE;
      pending_q         <= '0;
      rr_q              <= '0;
      act_q             <= '0;
      timer_q           <= '0;
      byte_cnt_q        <= '0;
      for (int i = 0; i < P_QUEUE_NUM; i++) begin
        budget_q[i] <= '0;
      end
      o_sched_done      <= 1'b0;
      o_done_qid        <= '0;
      o_done_bytes      <= '0;
      o_err             <= 1'b0;
      o_q_rd_byte       <= '0;
      o_q_rd_byte_valid <= '0;
      o_ddr_rd_addr     <= '0;
      o_ddr_rd_len      <= '0;
      o_ddr_rd_strb     <= '0;
      o_ddr_rd_qid      <= '0;
      o_ddr_rd_valid    <= 1'b0;
      o_busy            <= 1'b0;
    end else begin
      o_sched_done <= 1'b0;
      o_err        <= 1'b0;
      timer_q      <= timer_q + 1'b1;

      if (accept) begin
        pending_q[i_sched_qid] <= 1'b1;
        budget_q[i_sched_qid]  <= i_sched_byte;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            act_q                                   <= grant_qid_d;
            rr_q                                    <= grant_qid_d + 1'b1;
            o_q_rd_byte_valid[grant_qid_d]          <= 1'b1;
            o_q_rd_byte[int'(grant_qid_d)*AW +: AW] <= budget_q[grant_qid_d];
            byte_cnt_q                              <= '0;
            timer_q                                 <= '0;
            o_busy                                  <= 1'b1;
            state_q                                 <= S_BYTE;
          end
        end
        S_BYTE: begin
          if (i_q_rd_byte_ready[act_q]) begin
            o_q_rd_byte_valid <= '0;
            o_q_rd_byte       <= '0;
            timer_q           <= '0;
            state_q           <= S_CMD;
          end
        end
        S_CMD: begin
          if (i_q_rd_valid[act_q]) begin
            o_ddr_rd_addr  <= i_q_rd_addr[int'(act_q)*AW +: AW];
            o_ddr_rd_len   <= i_q_rd_len[int'(act_q)*16 +: 16];
            o_ddr_rd_strb  <= i_q_rd_strb[int'(act_q)*8 +: 8];
            o_ddr_rd_qid   <= act_q;
            o_ddr_rd_valid <= 1'b1;
            timer_q        <= '0;
            state_q        <= S_ISSUE;
          end else if (timer_q == TIMEOUT_LAST) begin
            o_sched_done <= 1'b1;
            o_err        <= 1'b1;
            o_done_qid   <= act_q;
            o_done_bytes <= byte_cnt_q;
            timer_q      <= '0;
            state_q      <= S_DONE;
          end
        end
        S_ISSUE: begin
          // Length is in 8-byte words; the byte count wraps freely.
          if (i_ddr_rd_ready) begin
            o_ddr_rd_valid <= 1'b0;
            byte_cnt_q     <= byte_cnt_q + AW'({o_ddr_rd_len, 3'b000});
            timer_q        <= '0;
            state_q        <= S_WAIT_CPL;
          end
        end
        S_WAIT_CPL: begin
          if (i_ddr_rd_cpl) begin
            timer_q <= '0;
            if (i_q_finish[act_q]) begin
              o_sched_done <= 1'b1;
              o_done_qid   <= act_q;
              o_done_bytes <= byte_cnt_q;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_CMD;
            end
          end else if (timer_q == TIMEOUT_LAST) begin
            o_sched_done <= 1'b1;
            o_err        <= 1'b1;
            o_done_qid   <= act_q;
            o_done_bytes <= byte_cnt_q;
            timer_q      <= '0;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          pending_q[act_q] <= 1'b0;
          o_busy           <= 1'b0;
          timer_q          <= '0;
          state_q          <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_queue_rd_scheduler.sv
// Self-checking bench for ddr_queue_rd_scheduler. A behavioural model of the
// request table and round-robin order predicts every grant, DDR command and
// done pulse; a queue/DDR responder plays the far side of each drain.
module tb_ddr_queue_rd_scheduler;

  localparam int QN = 4;
  localparam int AW = 32;
  localparam int TO = 1024;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_sched_valid = 1'b0;
  logic            o_sched_ready;
  logic [1:0]      i_sched_qid = '0;
  logic [AW-1:0]   i_sched_byte = '0;
  logic            o_sched_done;
  logic [1:0]      o_done_qid;
  logic [AW-1:0]   o_done_bytes;
  logic            o_err;
  logic [QN*AW-1:0] o_q_rd_byte;
  logic [QN-1:0]   o_q_rd_byte_valid;
  logic [QN-1:0]   i_q_rd_byte_ready = '0;
  logic [QN-1:0]   i_q_finish = '0;
  logic [QN*AW-1:0] i_q_rd_addr = '0;
  logic [QN*16-1:0] i_q_rd_len = '0;
  logic [QN*8-1:0] i_q_rd_strb = '0;
  logic [QN-1:0]   i_q_rd_valid = '0;
  logic [QN-1:0]   o_q_rd_ready;
  logic [QN-1:0]   o_q_rd_cpl;
  logic [AW-1:0]   o_ddr_rd_addr;
  logic [15:0]     o_ddr_rd_len;
  logic [7:0]      o_ddr_rd_strb;
  logic [1:0]      o_ddr_rd_qid;
  logic            o_ddr_rd_valid;
  logic            i_ddr_rd_ready = 1'b1;
  logic            i_ddr_rd_cpl = 1'b0;
  logic            o_busy;

  ddr_queue_rd_scheduler #(
    .P_QUEUE_NUM(QN), .C_M_AXI_ADDR_WIDTH(AW), .P_TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_sched_valid(i_sched_valid), .o_sched_ready(o_sched_ready),
    .i_sched_qid(i_sched_qid), .i_sched_byte(i_sched_byte),
    .o_sched_done(o_sched_done), .o_done_qid(o_done_qid),
    .o_done_bytes(o_done_bytes), .o_err(o_err),
    .o_q_rd_byte(o_q_rd_byte), .o_q_rd_byte_valid(o_q_rd_byte_valid),
    .i_q_rd_byte_ready(i_q_rd_byte_ready), .i_q_finish(i_q_finish),
    .i_q_rd_addr(i_q_rd_addr), .i_q_rd_len(i_q_rd_len),
    .i_q_rd_strb(i_q_rd_strb), .i_q_rd_valid(i_q_rd_valid),
    .o_q_rd_ready(o_q_rd_ready), .o_q_rd_cpl(o_q_rd_cpl),
    .o_ddr_rd_addr(o_ddr_rd_addr), .o_ddr_rd_len(o_ddr_rd_len),
    .o_ddr_rd_strb(o_ddr_rd_strb), .o_ddr_rd_qid(o_ddr_rd_qid),
    .o_ddr_rd_valid(o_ddr_rd_valid), .i_ddr_rd_ready(i_ddr_rd_ready),
    .i_ddr_rd_cpl(i_ddr_rd_cpl), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int numCompared = 0;
  int numMismatched = 0;
  int cycleCount = 0;

  always @(posedge i_clk) cycleCount <= cycleCount + 1;

  // Per-queue behaviour of the emulated local queues.
  int          cfgNcmd [QN];
  int          cfgLen [QN];
  logic [31:0] cfgAddr [QN];
  logic [7:0]  cfgStrb [QN];
  bit          cfgSilent [QN];
  int          cplDelay = 2;
  int          stallLeft = 0;

  // Model state and observation records.
  bit [QN-1:0] modelPending = '0;
  logic [31:0] modelBudget [QN];
  int          modelRr = 0;
  int          modelAct = 0;
  bit          modelActive = 0;
  int          modelCmdIdx = 0;
  int          grantLog [$];
  int          doneCount = 0;
  int          ddrCount = 0;
  int          cplCount = 0;
  int          stallCount = 0;
  int          lastDoneQid = 0;
  logic [31:0] lastDoneBytes = 0;
  int          lastDoneErr = 0;
  int          lastLatency = 0;
  int          cmdEntryCycle = 0;

  typedef enum {PH_IDLE, PH_CMD, PH_SENT, PH_CPL, PH_CPLSENT} phase_e;
  phase_e      rspPhase = PH_IDLE;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] req);
    numCompared++;
    if (got !== req) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cycleCount);
    end
  endtask

  // Presents one drain request for a single cycle and returns the ready seen.
  task automatic applyStimulus(input int qid, input logic [31:0] bytes, output bit rdy);
    @(posedge i_clk); #1;
    i_sched_valid = 1'b1;
    i_sched_qid   = 2'(qid);
    i_sched_byte  = bytes;
    @(negedge i_clk);
    rdy = o_sched_ready;
  endtask

  task automatic clearSched();
    @(posedge i_clk); #1;
    i_sched_valid = 1'b0;
    i_sched_byte  = '0;
  endtask

  task automatic waitDones(input int target, input int maxCyc);
    int n = 0;
    while (doneCount < target && n < maxCyc) begin
      @(negedge i_clk);
      n++;
    end
    if (doneCount < target) checkOutput("wait_done_timeout", doneCount, target);
  endtask

  task automatic waitActive(input int q, input int maxCyc);
    int n = 0;
    while (!(modelActive && modelAct == q) && n < maxCyc) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("wait_active", modelActive ? modelAct : -1, q);
  endtask

  // Queue and DDR side responder: observes handshakes on the falling edge,
  // then drives the next cycle's inputs just after the rising edge.
  initial begin : responder
    int rq = 0, idx = 0, cd = 0, byteQ = 0;
    bit hsByte, hsDdr, cplNow;
    forever begin
      @(negedge i_clk);
      hsByte = 0;
      for (int q = 0; q < QN; q++) begin
        if (o_q_rd_byte_valid[q] && i_q_rd_byte_ready[q]) begin
          hsByte = 1;
          byteQ  = q;
        end
      end
      hsDdr  = o_ddr_rd_valid && i_ddr_rd_ready;
      cplNow = i_ddr_rd_cpl;
      @(posedge i_clk); #1;
      i_q_rd_valid = '0;
      i_ddr_rd_cpl = 1'b0;
      i_q_finish   = '0;
      if (i_rst) begin
        rspPhase          = PH_IDLE;
        i_q_rd_byte_ready = '0;
        i_ddr_rd_ready    = 1'b1;
        continue;
      end
      i_q_rd_byte_ready = o_q_rd_byte_valid;
      if (hsByte) begin
        rq = byteQ; idx = 0; rspPhase = PH_CMD; cmdEntryCycle = cycleCount;
      end
      if (hsDdr) begin
        rspPhase = PH_CPL; cd = cplDelay;
      end
      if (cplNow && rspPhase == PH_CPLSENT) begin
        idx++;
        rspPhase = (idx >= cfgNcmd[rq]) ? PH_IDLE : PH_CMD;
      end
      if (rspPhase == PH_CMD && !cfgSilent[rq] && o_q_rd_ready[rq]) begin
        i_q_rd_valid[rq]          = 1'b1;
        i_q_rd_addr[rq*32 +: 32]  = cfgAddr[rq] + 32'(idx * cfgLen[rq] * 8);
        i_q_rd_len[rq*16 +: 16]   = 16'(cfgLen[rq]);
        i_q_rd_strb[rq*8 +: 8]    = cfgStrb[rq];
        rspPhase = PH_SENT;
      end
      if (rspPhase == PH_CPL) begin
        if (cd == 0) begin
          i_ddr_rd_cpl   = 1'b1;
          i_q_finish[rq] = (idx == cfgNcmd[rq] - 1);
          rspPhase = PH_CPLSENT;
        end else begin
          cd--;
        end
      end
      if (o_ddr_rd_valid && stallLeft > 0) begin
        i_ddr_rd_ready = 1'b0;
        stallLeft--;
      end else begin
        i_ddr_rd_ready = 1'b1;
      end
    end
  end

  // Compare process: checks every cycle against the request-table model.
  initial begin : compare
    bit [QN-1:0] pendNow, pendPrev;
    logic [QN-1:0] prevByteValid;
    int pick;
    logic [31:0] expBytes;
    pendPrev = '0;
    prevByteValid = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        modelPending = '0; modelRr = 0; modelActive = 0;
        pendPrev = '0; prevByteValid = '0;
        continue;
      end
      pendNow = modelPending;
      if (o_q_rd_byte_valid != '0 && prevByteValid == '0) begin
        pick = -1;
        for (int k = 0; k < QN; k++) begin
          if (pick < 0 && pendPrev[(modelRr + k) % QN]) pick = (modelRr + k) % QN;
        end
        if (pick < 0) begin
          checkOutput("grant_unexpected", o_q_rd_byte_valid, 0);
        end else begin
          checkOutput("grant_qid", o_q_rd_byte_valid, 4'b0001 << pick);
          checkOutput("grant_budget", o_q_rd_byte[pick*32 +: 32], modelBudget[pick]);
          modelAct = pick; modelActive = 1; modelRr = (pick + 1) % QN;
          modelCmdIdx = 0;
          grantLog.push_back(pick);
        end
      end
      prevByteValid = o_q_rd_byte_valid;
      if (modelActive) checkOutput("rd_ready_isolation", o_q_rd_ready & ~(4'b0001 << modelAct), 0);
      else             checkOutput("rd_ready_idle", o_q_rd_ready, 0);
      checkOutput("cpl_relay", o_q_rd_cpl, (i_ddr_rd_cpl && modelActive) ? (4'b0001 << modelAct) : 4'b0000);
      if (o_q_rd_cpl != '0) cplCount++;
      if (o_ddr_rd_valid) begin
        checkOutput("ddr_while_active", modelActive, 1);
        checkOutput("ddr_addr", o_ddr_rd_addr, cfgAddr[modelAct] + 32'(modelCmdIdx * cfgLen[modelAct] * 8));
        checkOutput("ddr_len", o_ddr_rd_len, cfgLen[modelAct]);
        checkOutput("ddr_strb", o_ddr_rd_strb, cfgStrb[modelAct]);
        checkOutput("ddr_qid", o_ddr_rd_qid, modelAct);
        if (i_ddr_rd_ready) begin
          modelCmdIdx++; ddrCount++;
        end else begin
          stallCount++;
        end
      end
      if (o_sched_done) begin
        checkOutput("done_expected", modelActive, 1);
        expBytes = cfgSilent[modelAct] ? 32'd0 : 32'(cfgNcmd[modelAct] * cfgLen[modelAct] * 8);
        checkOutput("done_qid", o_done_qid, modelAct);
        checkOutput("done_bytes", o_done_bytes, expBytes);
        checkOutput("done_err", o_err, cfgSilent[modelAct]);
        lastDoneQid = o_done_qid; lastDoneBytes = o_done_bytes; lastDoneErr = o_err;
        lastLatency = cycleCount - cmdEntryCycle;
        if (modelActive) modelPending[modelAct] = 1'b0;
        modelActive = 0;
        doneCount++;
      end else begin
        checkOutput("err_without_done", o_err, 0);
      end
      if (i_sched_valid) begin
        checkOutput("sched_ready", o_sched_ready, !pendNow[i_sched_qid]);
        if (!pendNow[i_sched_qid] && i_sched_byte != '0) begin
          modelPending[i_sched_qid] = 1'b1;
          modelBudget[i_sched_qid]  = i_sched_byte;
        end
      end
      pendPrev = pendNow;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence with hand-computed expectations.
  initial begin : main
    bit rdy;
    int dBase, cBase, gBase, sBase;
    for (int q = 0; q < QN; q++) begin
      cfgNcmd[q] = 1; cfgLen[q] = 4; cfgAddr[q] = 32'h1000_0000 * (q + 1);
      cfgStrb[q] = 8'hF0 | 8'(q); cfgSilent[q] = 0; modelBudget[q] = 0;
    end

    $display("[TB] reset");
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #2;
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_done", o_sched_done, 0);
    checkOutput("reset_ddr_valid", o_ddr_rd_valid, 0);
    checkOutput("reset_byte_valid", o_q_rd_byte_valid, 0);
    @(negedge i_clk); #2;
    i_rst = 1'b0;

    $display("[TB] single drain q2");
    cfgNcmd[2] = 3; cfgLen[2] = 128; cfgAddr[2] = 32'h0000_1000; cfgStrb[2] = 8'hFF;
    cplDelay = 3;
    dBase = ddrCount; cBase = cplCount;
    applyStimulus(2, 4096, rdy);
    clearSched();
    waitDones(1, 200);
    checkOutput("t1_done_qid", lastDoneQid, 2);
    checkOutput("t1_done_bytes", lastDoneBytes, 3072);
    checkOutput("t1_ddr_cmds", ddrCount - dBase, 3);
    checkOutput("t1_cpl_pulses", cplCount - cBase, 3);

    $display("[TB] round robin");
    cfgNcmd[3] = 2; cfgLen[3] = 8;
    cplDelay = 10;
    gBase = grantLog.size();
    applyStimulus(0, 100, rdy);
    applyStimulus(1, 200, rdy);
    applyStimulus(3, 300, rdy);
    clearSched();
    waitActive(3, 200);
    applyStimulus(0, 64, rdy);
    checkOutput("t2_late_q0_ready", rdy, 1);
    clearSched();
    waitDones(5, 400);
    checkOutput("t2_grant_count", grantLog.size() - gBase, 4);
    if (grantLog.size() >= gBase + 4) begin
      checkOutput("t2_grant0", grantLog[gBase], 0);
      checkOutput("t2_grant1", grantLog[gBase + 1], 1);
      checkOutput("t2_grant2", grantLog[gBase + 2], 3);
      checkOutput("t2_grant3", grantLog[gBase + 3], 0);
    end
    checkOutput("t2_q3_bytes_seen", lastDoneBytes, 32);

    $display("[TB] backpressure");
    cfgNcmd[1] = 1; cfgLen[1] = 16; cplDelay = 1;
    stallLeft = 20;
    sBase = stallCount;
    applyStimulus(1, 512, rdy);
    clearSched();
    waitDones(6, 200);
    checkOutput("t3_stall_cycles", stallCount - sBase, 20);
    checkOutput("t3_done_bytes", lastDoneBytes, 128);

    $display("[TB] timeout");
    cfgSilent[0] = 1;
    applyStimulus(0, 1000, rdy);
    clearSched();
    waitDones(7, TO + 100);
    checkOutput("t4_err", lastDoneErr, 1);
    checkOutput("t4_bytes", lastDoneBytes, 0);
    checkOutput("t4_qid", lastDoneQid, 0);
    checkOutput("t4_latency", lastLatency, TO);
    cfgSilent[0] = 0;

    $display("[TB] duplicate and zero budget");
    cfgNcmd[2] = 2; cfgLen[2] = 32; cplDelay = 30;
    gBase = grantLog.size();
    applyStimulus(2, 2048, rdy);
    clearSched();
    waitActive(2, 50);
    applyStimulus(1, 256, rdy);
    checkOutput("t5_first_q1_ready", rdy, 1);
    applyStimulus(1, 512, rdy);
    checkOutput("t5_dup_q1_ready", rdy, 0);
    applyStimulus(3, 0, rdy);
    checkOutput("t5_zero_q3_ready", rdy, 1);
    clearSched();
    waitDones(9, 400);
    repeat (20) @(negedge i_clk);
    checkOutput("t5_done_count", doneCount, 9);
    checkOutput("t5_grant_count", grantLog.size() - gBase, 2);
    checkOutput("t5_last_qid", lastDoneQid, 1);

    $display("[TB] async reset in WAIT_CPL");
    cfgNcmd[2] = 1; cfgLen[2] = 8; cplDelay = 60;
    applyStimulus(2, 64, rdy);
    clearSched();
    begin
      int n = 0;
      while (rspPhase != PH_CPL && n < 100) begin
        @(negedge i_clk);
        n++;
      end
      checkOutput("t6_reached_wait_cpl", rspPhase == PH_CPL, 1);
    end
    repeat (5) @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("t6_busy", o_busy, 0);
    checkOutput("t6_ddr_valid", o_ddr_rd_valid, 0);
    checkOutput("t6_rd_ready", o_q_rd_ready, 0);
    checkOutput("t6_rd_cpl", o_q_rd_cpl, 0);
    checkOutput("t6_done_bytes", o_done_bytes, 0);
    checkOutput("t6_done_qid", o_done_qid, 0);
    checkOutput("t6_byte_any", |o_q_rd_byte, 0);
    checkOutput("t6_ddr_addr", o_ddr_rd_addr, 0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #2;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("t6_idle_after", o_busy, 0);
    checkOutput("t6_rr_after", dut.rr_q, 0);
    dBase = doneCount;
    cplDelay = 2;
    applyStimulus(1, 100, rdy);
    clearSched();
    waitDones(dBase + 1, 200);
    checkOutput("t6_post_done_qid", lastDoneQid, 1);
    checkOutput("t6_post_done_bytes", lastDoneBytes, 128);

    repeat (5) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
